// File: rtl/fifo_drain_pkg.sv
// Shared helpers for the FIFO drain serializer: lane count, beat index width
// and the parameter legality rule that the top module enforces at elaboration.
package fifo_drain_pkg;

  // Number of OUT_W beats that make up one DATA_W word.
  function automatic int calcLanes(input int dataW, input int outW);
    return (outW > 0) ? (dataW / outW) : 1;
  endfunction

  // Beat index width; at least one bit so a single-lane build still has a counter.
  function automatic int calcIdxW(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  // A word must split into a whole number of beats.
  function automatic bit widthLegal(input int dataW, input int outW);
    return (outW > 0) && (dataW >= outW) && ((dataW % outW) == 0);
  endfunction

endpackage

// File: rtl/fifo_drain_serializer_beat_select.sv
// Picks the OUT_W slice of the active word that corresponds to the current
// beat index, honouring the configured beat order.
module beat_select
  import fifo_drain_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int OUT_W     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [DATA_W-1:0]                           word_i,
  input  logic [calcIdxW(calcLanes(DATA_W,OUT_W))-1:0] idx_i,
  output logic [OUT_W-1:0]                            beat_o
);

  localparam int LANES = calcLanes(DATA_W, OUT_W);
  localparam int IDX_W = calcIdxW(LANES);

  // Constant-index mux: beat 0 is the top slice when MSB_FIRST, else the bottom slice.
  always_comb begin
    beat_o = '0;
    for (int i = 0; i < LANES; i++) begin
      if (idx_i == IDX_W'(i)) begin
        beat_o = MSB_FIRST ? word_i[(LANES-1-i)*OUT_W +: OUT_W]
                           : word_i[i*OUT_W +: OUT_W];
      end
    end
  end

endmodule

// File: rtl/fifo_drain_serializer.sv
// Drains words from a single-port FIFO and emits them as narrow valid/ready
// beats. One active word plus one prefetched word keep the stream gapless;
// at most one FIFO read is ever in flight.
module fifo_drain_serializer
  import fifo_drain_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int OUT_W     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_cen,
  output logic              fifo_rw,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int LANES = calcLanes(DATA_W, OUT_W);
  localparam int IDX_W = calcIdxW(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  if (!widthLegal(DATA_W, OUT_W)) begin : gIllegalWidths
    $error("fifo_drain_serializer: DATA_W must be a positive multiple of OUT_W");
  end

  logic [DATA_W-1:0] actWord_q, actWord_d;
  logic [DATA_W-1:0] pfWord_q, pfWord_d;
  logic              actValid_q, actValid_d;
  logic              pfValid_q, pfValid_d;
  logic              rdPend_q, rdPend_d;
  logic [IDX_W-1:0]  beatIdx_q, beatIdx_d;
  logic [CNT_W-1:0]  wordCnt_q, wordCnt_d;

  logic [1:0]        occupancy;
  logic              beatHs;
  logic              lastHs;
  logic [OUT_W-1:0]  beatData;

  // Reads are gated by the in-flight flag so the FIFO's empty flag is always
  // post-read when sampled again, and by occupancy so a returning word always
  // has a free slot.
  assign occupancy = {1'b0, actValid_q} + {1'b0, pfValid_q};
  assign fifo_cen  = en & ~fifo_empty & ~reset & ~rdPend_q & (occupancy < 2'd2);
  assign fifo_rw   = 1'b1;

  assign beatHs = actValid_q & out_ready;
  assign lastHs = beatHs & (beatIdx_q == LAST_IDX);

  beat_select #(
    .DATA_W   (DATA_W),
    .OUT_W    (OUT_W),
    .MSB_FIRST(MSB_FIRST)
  ) uBeatSelect (
    .word_i(actWord_q),
    .idx_i (beatIdx_q),
    .beat_o(beatData)
  );

  // Next state: advance the beat on handshake, promote the prefetch word on the
  // last beat, then place returning read data into whichever slot is free.
  always_comb begin
    actWord_d  = actWord_q;
    pfWord_d   = pfWord_q;
    actValid_d = actValid_q;
    pfValid_d  = pfValid_q;
    beatIdx_d  = beatIdx_q;
    wordCnt_d  = wordCnt_q;
    rdPend_d   = fifo_cen;

    if (beatHs) begin
      if (lastHs) begin
        wordCnt_d = wordCnt_q + 1'b1;
        beatIdx_d = '0;
        if (pfValid_q) begin
          actWord_d = pfWord_q;
          pfValid_d = 1'b0;
        end else begin
          actValid_d = 1'b0;
        end
      end else begin
        beatIdx_d = beatIdx_q + 1'b1;
      end
    end

    if (rdPend_q) begin
      if (!actValid_d) begin
        actWord_d  = fifo_data;
        actValid_d = 1'b1;
        beatIdx_d  = '0;
      end else begin
        pfWord_d  = fifo_data;
        pfValid_d = 1'b1;
      end
    end
  end

  // State registers; reset drops everything, including any in-flight read.
  always_ff @(posedge clk) begin
    if (reset) begin
      actWord_q  <= '0;
      pfWord_q   <= '0;
      actValid_q <= 1'b0;
      pfValid_q  <= 1'b0;
      rdPend_q   <= 1'b0;
      beatIdx_q  <= '0;
      wordCnt_q  <= '0;
    end else begin
      actWord_q  <= actWord_d;
      pfWord_q   <= pfWord_d;
      actValid_q <= actValid_d;
      pfValid_q  <= pfValid_d;
      rdPend_q   <= rdPend_d;
      beatIdx_q  <= beatIdx_d;
      wordCnt_q  <= wordCnt_d;
    end
  end

  assign out_valid = actValid_q;
  assign out_data  = actValid_q ? beatData : '0;
  assign out_first = actValid_q & (beatIdx_q == '0);
  assign out_last  = actValid_q & (beatIdx_q == LAST_IDX);
  assign busy      = actValid_q | pfValid_q | rdPend_q;
  assign word_cnt  = wordCnt_q;

endmodule
